// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: fetch sequencer for a combinational-read instruction memory.
//   i_clk/i_rst                clock, synchronous active-high reset
//   i_halt                     stop new fetches; queued words still drain
//   i_redirect/i_redirect_pc   flush queue and restart fetch at the word-aligned target
//   o_imem_addr/o_imem_req     fetch PC to memory; req marks the word captured this cycle
//   i_imem_inst                word returned combinationally for o_imem_addr
//   o_inst_valid/o_inst/o_inst_pc/i_inst_ready   head of prefetch queue toward decode
//   o_misalign                 one-cycle pulse after a redirect to a non-4-aligned target
module imem_fetch_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                QDEPTH   = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_halt,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic              o_imem_req,
    input  logic [31:0]       i_imem_inst,
    output logic              o_inst_valid,
    output logic [31:0]       o_inst,
    output logic [ADDR_W-1:0] o_inst_pc,
    input  logic              i_inst_ready,
    output logic              o_misalign
);
    localparam int QW = $clog2(QDEPTH);
    localparam logic [QW:0] CAP = (QW+1)'(QDEPTH);

    logic [ADDR_W-1:0] pc;
    logic [31:0]       q_inst [QDEPTH];
    logic [ADDR_W-1:0] q_pc   [QDEPTH];
    logic [QW-1:0]     wr_ptr, rd_ptr;
    logic [QW:0]       count;
    logic              misalign;
    logic              pop, push;

    // valid is masked by redirect so decode never takes an entry being flushed
    assign o_inst_valid = (count != '0) && !i_redirect;
    assign pop          = o_inst_valid && i_inst_ready;
    // a full queue may still accept a word when the head leaves in the same cycle
    assign push         = !i_rst && !i_redirect && !i_halt && ((count < CAP) || pop);
    assign o_imem_req   = push;
    assign o_imem_addr  = pc;
    assign o_inst       = o_inst_valid ? q_inst[rd_ptr] : '0;
    assign o_inst_pc    = o_inst_valid ? q_pc[rd_ptr] : '0;
    assign o_misalign   = misalign;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc       <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            misalign <= 1'b0;
        end else if (i_redirect) begin
            pc       <= {i_redirect_pc[ADDR_W-1:2], 2'b00};
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            misalign <= |i_redirect_pc[1:0];
        end else begin
            misalign <= 1'b0;
            if (push) begin
                q_inst[wr_ptr] <= i_imem_inst;
                q_pc[wr_ptr]   <= pc;
                wr_ptr         <= wr_ptr + 1'b1;
                pc             <= pc + ADDR_W'(4);
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (QW+1)'(push) - (QW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: scoreboard bench for imem_fetch_ctrl (32-bit instance plus 8-bit wrap instance).
module tb_imem_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst, halt, redirect, ready;
    logic [31:0] rpc, addr, inst, o_inst, o_pc;
    logic        req, valid, misalign;

    logic        b_rst, b_halt, b_redirect, b_ready;
    logic [7:0]  b_rpc, b_addr, b_pc;
    logic [31:0] b_inst, b_o_inst;
    logic        b_req, b_valid, b_misalign;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_a [$];
    logic [7:0]  exp_b [$];

    always #5 clk = ~clk;

    assign inst   = addr ^ 32'h5a5a_0000;
    assign b_inst = {24'h0, b_addr} ^ 32'h5a5a_0000;

    imem_fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'h0), .QDEPTH(2)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_halt(halt), .i_redirect(redirect), .i_redirect_pc(rpc),
        .o_imem_addr(addr), .o_imem_req(req), .i_imem_inst(inst), .o_inst_valid(valid),
        .o_inst(o_inst), .o_inst_pc(o_pc), .i_inst_ready(ready), .o_misalign(misalign)
    );

    imem_fetch_ctrl #(.ADDR_W(8), .RESET_PC(8'h10), .QDEPTH(2)) dut_b (
        .i_clk(clk), .i_rst(b_rst), .i_halt(b_halt), .i_redirect(b_redirect), .i_redirect_pc(b_rpc),
        .o_imem_addr(b_addr), .o_imem_req(b_req), .i_imem_inst(b_inst), .o_inst_valid(b_valid),
        .o_inst(b_o_inst), .o_inst_pc(b_pc), .i_inst_ready(b_ready), .o_misalign(b_misalign)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (valid && ready) begin
            check("sb_a_pending", 32'(exp_a.size() > 0), 32'd1);
            if (exp_a.size() > 0) begin
                logic [31:0] e;
                e = exp_a.pop_front();
                check("sb_a_pc", o_pc, e);
                check("sb_a_inst", o_inst, e ^ 32'h5a5a_0000);
            end
        end
        if (b_valid && b_ready) begin
            check("sb_b_pending", 32'(exp_b.size() > 0), 32'd1);
            if (exp_b.size() > 0) begin
                logic [7:0] e;
                e = exp_b.pop_front();
                check("sb_b_pc", {24'h0, b_pc}, {24'h0, e});
                check("sb_b_inst", b_o_inst, {24'h0, e} ^ 32'h5a5a_0000);
            end
        end
    end

    initial begin
        rst = 1'b1; halt = 1'b0; redirect = 1'b0; ready = 1'b0; rpc = '0;
        b_rst = 1'b1; b_halt = 1'b0; b_redirect = 1'b0; b_ready = 1'b0; b_rpc = '0;
        nxt();
        smp();
        check("rst_valid", 32'(valid), 0);
        check("rst_req", 32'(req), 0);
        check("rst_misalign", 32'(misalign), 0);
        check("rst_addr", addr, 0);
        check("rst_inst", o_inst, 0);
        check("rst_inst_pc", o_pc, 0);
        nxt();
        rst = 1'b0; ready = 1'b1;
        for (int i = 0; i < 5; i++) exp_a.push_back(32'(i * 4));
        smp();
        check("rel_valid", 32'(valid), 0);
        check("rel_req", 32'(req), 1);
        check("rel_addr", addr, 0);
        nxt();
        smp();
        check("fill_valid", 32'(valid), 1);
        nxt();
        repeat (4) nxt();
        rst = 1'b1; ready = 1'b0;
        smp();
        check("midrst_req", 32'(req), 0);
        nxt();
        rst = 1'b0;
        smp();
        check("postrst_valid", 32'(valid), 0);
        check("postrst_addr", addr, 0);
        nxt();
        nxt();
        smp();
        check("bp_req", 32'(req), 0);
        check("bp_addr", addr, 32'h8);
        nxt();
        nxt();
        smp();
        check("bp_req_hold", 32'(req), 0);
        check("bp_addr_hold", addr, 32'h8);
        check("bp_valid", 32'(valid), 1);
        check("bp_head", o_pc, 32'h0);
        nxt();
        ready = 1'b1;
        for (int i = 0; i < 3; i++) exp_a.push_back(32'(i * 4));
        smp();
        check("full_pop_req", 32'(req), 1);
        check("full_pop_addr", addr, 32'h8);
        nxt();
        repeat (2) nxt();
        redirect = 1'b1; rpc = 32'h100;
        smp();
        check("redir_valid", 32'(valid), 0);
        check("redir_req", 32'(req), 0);
        nxt();
        redirect = 1'b0;
        exp_a.push_back(32'h100); exp_a.push_back(32'h104);
        smp();
        check("redir1_valid", 32'(valid), 0);
        check("redir1_addr", addr, 32'h100);
        check("redir1_misalign", 32'(misalign), 0);
        nxt();
        smp();
        check("redir2_valid", 32'(valid), 1);
        nxt();
        nxt();
        redirect = 1'b1; rpc = 32'h102;
        smp();
        check("mis_valid", 32'(valid), 0);
        nxt();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) exp_a.push_back(32'h100 + 32'(i * 4));
        smp();
        check("mis_pulse", 32'(misalign), 1);
        check("mis_addr", addr, 32'h100);
        check("mis_valid1", 32'(valid), 0);
        nxt();
        smp();
        check("mis_once", 32'(misalign), 0);
        nxt();
        repeat (2) nxt();
        redirect = 1'b1; rpc = 32'h200;
        nxt();
        rpc = 32'h300;
        smp();
        check("b2b_valid", 32'(valid), 0);
        nxt();
        redirect = 1'b0;
        exp_a.push_back(32'h300); exp_a.push_back(32'h304);
        smp();
        check("b2b_addr", addr, 32'h300);
        nxt();
        nxt();
        halt = 1'b1;
        smp();
        check("halt_req", 32'(req), 0);
        check("halt_drain_valid", 32'(valid), 1);
        nxt();
        smp();
        check("halt_empty_valid", 32'(valid), 0);
        check("halt_empty_req", 32'(req), 0);
        check("halt_addr", addr, 32'h308);
        nxt();
        smp();
        check("halt_addr_hold", addr, 32'h308);
        nxt();
        halt = 1'b0;
        exp_a.push_back(32'h308); exp_a.push_back(32'h30c);
        smp();
        check("resume_req", 32'(req), 1);
        check("resume_addr", addr, 32'h308);
        check("resume_valid", 32'(valid), 0);
        nxt();
        repeat (2) nxt();
        ready = 1'b0;
        nxt();
        check("sb_a_drained", 32'(exp_a.size()), 0);

        b_rst = 1'b0; b_redirect = 1'b1; b_rpc = 8'hf8; b_ready = 1'b1;
        exp_b.push_back(8'hf8); exp_b.push_back(8'hfc);
        exp_b.push_back(8'h00); exp_b.push_back(8'h04);
        nxt();
        b_redirect = 1'b0;
        smp();
        check("wrap_addr", {24'h0, b_addr}, 32'hf8);
        nxt();
        repeat (2) nxt();
        smp();
        check("wrap_zero_pc", {24'h0, b_pc}, 32'h0);
        check("wrap_zero_valid", 32'(b_valid), 1);
        nxt();
        nxt();
        b_ready = 1'b0;
        nxt();
        check("sb_b_drained", 32'(exp_b.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Fetch sequencer for the combinational-read instruction memory.
- Owns the fetch PC and drives the memory address each cycle.
- Captures the returned word with its PC into a small prefetch queue.
- Presents instructions to decode over a valid/ready handshake; handles redirects (branch/jump/trap) and halt.

Parameters:
- ADDR_W, 32, width of instruction address and PC.
- RESET_PC, 0, fetch PC after reset; must be 4-aligned.
- QDEPTH, 2, prefetch queue entries; power of two, at least 2.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_halt  input  1  suppress new fetches; queue contents still drain.
- i_redirect  input  1  flush queue and restart fetch at i_redirect_pc.
- i_redirect_pc  input  ADDR_W  redirect target.
- o_imem_addr  output  ADDR_W  address to instruction memory; always equals the fetch PC register.
- o_imem_req  output  1  high when the word at o_imem_addr is captured this cycle.
- i_imem_inst  input  32  instruction word returned combinationally by memory.
- o_inst_valid  output  1  queue head valid toward decode.
- o_inst  output  32  head instruction.
- o_inst_pc  output  ADDR_W  PC of head instruction.
- i_inst_ready  input  1  decode accepts the head this cycle.
- o_misalign  output  1  one-cycle pulse: accepted redirect target had bits [1:0] nonzero.

Behaviour:
- Reset, while i_rst=1 at an edge:
  - fetch PC = RESET_PC.
  - Queue empty (read/write pointers and count = 0).
  - o_inst_valid=0, o_imem_req=0, o_misalign=0.
  - o_inst and o_inst_pc are don't-care while invalid; tied to 0 for determinism.
  - Reset mid-operation discards all queue content and any pending redirect effect.
- Pop:
  - Occurs when o_inst_valid and i_inst_ready and not i_redirect.
  - o_inst_valid = (count != 0) and not i_redirect. This is combinational; decode never sees stale entries in the flush cycle.
- Push (o_imem_req), evaluated in the same cycle:
  - o_imem_req = not i_rst and not i_redirect and not i_halt and (count < QDEPTH or pop).
  - Push while full is allowed only with a simultaneous pop.
  - On push: the queue tail gets {i_imem_inst, fetch PC}, and fetch PC increments by 4 modulo 2^ADDR_W (wraps from the top to 0, no flag).
  - Count updates: +1 for push only, -1 for pop only, unchanged for both or neither.
- Redirect (highest priority after reset):
  - Queue flushed (count=0, pointers reset).
  - fetch PC = {i_redirect_pc[ADDR_W-1:2], 2'b00}.
  - o_misalign=1 in the next cycle iff i_redirect_pc[1:0] != 0, else 0.
  - No push and no pop in the redirect cycle.
  - Latency: redirect in cycle N gives o_imem_addr=target in N+1 and o_inst_valid=1 with o_inst_pc=target in N+2, unless halted or i_redirect is held.
  - Back-to-back redirects: the last one wins.
- Halt:
  - Stops pushes only. Fetch PC holds; the queue drains by pops.
  - Deasserting halt resumes fetching from the held PC with no gap or duplicate.
- Steady state: with ready held high and no halt, one instruction per cycle; PCs increase by 4 with no bubbles after initial fill.
- Ordering: instructions are delivered strictly in fetch order. No instruction is lost or duplicated except those discarded by redirect/reset.
- Queue pointers are log2(QDEPTH) bits and wrap naturally.

Test Plan:
- Reset release, RESET_PC=0x0, ready=1, memory word = address: o_inst_valid rises 1 cycle after reset release; PCs 0x0, 0x4, 0x8... on consecutive cycles; o_inst == o_inst_pc.
- Backpressure: ready=0 for 5 cycles. After 2 pushes count=2, o_imem_req=0, o_imem_addr held at 0x8. Ready=1 then yields 0x0, 0x4, 0x8 in consecutive cycles with no gap.
- Redirect with full queue plus simultaneous ready=1 to 0x100: no pop that cycle, o_inst_valid=0 that cycle and next. o_inst_pc=0x100 valid 2 cycles later, then 0x104.
- Misaligned redirect to 0x102: o_misalign pulses exactly once the next cycle; first delivered PC is 0x100.
- Wrap: ADDR_W=8, redirect to 0xF8, ready=1: delivered PCs are 0xF8, 0xFC, 0x00, 0x04.
- Halt and reset: halt=1 with 1 queued entry; it drains, then valid=0 and addr held. Halt=0 resumes at the held PC. Asserting i_rst mid-stream gives valid=0 next cycle, and fetch restarts at RESET_PC after release.
